// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch / countdown family of BCD blocks.
package stopwatch_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } cd_state_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd2_t      BCD_ZERO = 8'h00;

  // Wrapping single-digit increment used while the user dials in a preset.
  function automatic bcd_digit_t bcdInc(input bcd_digit_t d, input bcd_digit_t maxVal);
    return (d >= maxVal) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Combinational single BCD digit decrement with borrow chaining.
module bcd_digit_dec
  import stopwatch_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t digit_out,
  output logic       borrow_out
);

  always_comb begin
    digit_out  = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_out  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// Two-digit BCD countdown timer: set a preset, run on second ticks, alarm at 00.
module bcd_countdown
  import stopwatch_pkg::*;
#(
  parameter int unsigned TENS_MAX = 9
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       second_tick,
  input  logic       one_inc,
  input  logic       ten_inc,
  input  logic       start_stop,
  input  logic       clear,
  output logic [7:0] number,
  output logic [1:0] state,
  output logic       done,
  output logic       alarm
);

  localparam bcd_digit_t TensMax = bcd_digit_t'(TENS_MAX);

  cd_state_t state_q, state_d;
  bcd2_t     number_q, number_d;
  bcd2_t     preset_q, preset_d;
  logic      done_q, done_d;
  logic      alarm_q, alarm_d;

  bcd2_t numberDec;
  logic  onesBorrow;
  logic  tensBorrow;

  bcd_digit_dec onesDec (
    .digit      (number_q.ones),
    .borrow_in  (1'b1),
    .digit_out  (numberDec.ones),
    .borrow_out (onesBorrow)
  );

  bcd_digit_dec tensDec (
    .digit      (number_q.tens),
    .borrow_in  (onesBorrow),
    .digit_out  (numberDec.tens),
    .borrow_out (tensBorrow)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= SET;
      number_q <= BCD_ZERO;
      preset_q <= BCD_ZERO;
      done_q   <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      number_q <= number_d;
      preset_q <= preset_d;
      done_q   <= done_d;
      alarm_q  <= alarm_d;
    end
  end

  // Only the highest-priority applicable event acts: clear, start_stop, tick, inc.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = SET;
    end else begin
      case (state_q)
        SET:   if (start_stop && number_q != BCD_ZERO) state_d = RUN;
        RUN: begin
          if (start_stop)                                   state_d = PAUSE;
          else if (second_tick && number_q == bcd2_t'(8'h01)) state_d = DONE;
        end
        PAUSE: if (start_stop) state_d = RUN;
        DONE:  if (start_stop) state_d = SET;
        default: state_d = SET;
      endcase
    end
  end

  // tensBorrow flags a decrement from 00, which must never wrap to 99.
  always_comb begin
    number_d = number_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (clear) begin
      number_d = BCD_ZERO;
    end else begin
      case (state_q)
        SET: begin
          if (start_stop && number_q != BCD_ZERO) begin
            preset_d = number_q;
          end else begin
            if (one_inc) number_d.ones = bcdInc(number_q.ones, BCD_MAX);
            if (ten_inc) number_d.tens = bcdInc(number_q.tens, TensMax);
          end
        end
        RUN: begin
          if (!start_stop && second_tick && !tensBorrow) begin
            number_d = numberDec;
            done_d   = (numberDec == BCD_ZERO);
          end
        end
        DONE: if (start_stop) number_d = preset_q;
        default: number_d = number_q;
      endcase
    end
    alarm_d = (state_d == DONE);
  end

  assign number = number_q;
  assign state  = state_q;
  assign done   = done_q;
  assign alarm  = alarm_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown with hand-computed expectations.
module tb_bcd_countdown;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       second_tick, one_inc, ten_inc, start_stop, clear;
  logic [7:0] number, number5;
  logic [1:0] state, state5;
  logic       done, alarm, done5, alarm5;

  int total = 0;
  int bad   = 0;

  logic [7:0] tickExp [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] tensExp [6]  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h00};

  always #5 clk = ~clk;

  bcd_countdown #(.TENS_MAX(9)) dut (
    .clk(clk), .n_rst(n_rst), .second_tick(second_tick), .one_inc(one_inc),
    .ten_inc(ten_inc), .start_stop(start_stop), .clear(clear),
    .number(number), .state(state), .done(done), .alarm(alarm)
  );

  bcd_countdown #(.TENS_MAX(5)) dut5 (
    .clk(clk), .n_rst(n_rst), .second_tick(second_tick), .one_inc(one_inc),
    .ten_inc(ten_inc), .start_stop(start_stop), .clear(clear),
    .number(number5), .state(state5), .done(done5), .alarm(alarm5)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [7:0] num, input logic [1:0] st,
                          input logic dn, input logic al);
    checkOutput({tag, ".number"}, number, num);
    checkOutput({tag, ".state"}, {6'd0, state}, {6'd0, st});
    checkOutput({tag, ".done"}, {7'd0, done}, {7'd0, dn});
    checkOutput({tag, ".alarm"}, {7'd0, alarm}, {7'd0, al});
  endtask

  // One clock of input pulses, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic o, input logic t, input logic ss,
                               input logic tk, input logic clr);
    one_inc     = o;
    ten_inc     = t;
    start_stop  = ss;
    second_tick = tk;
    clear       = clr;
    @(posedge clk);
    #1;
    one_inc     = 1'b0;
    ten_inc     = 1'b0;
    start_stop  = 1'b0;
    second_tick = 1'b0;
    clear       = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    {second_tick, one_inc, ten_inc, start_stop, clear} = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    n_rst = 1'b1;

    repeat (3) applyStimulus(1, 0, 0, 0, 0);
    repeat (2) applyStimulus(0, 1, 0, 0, 0);
    checkAll("set23", 8'h23, 2'd0, 1'b0, 1'b0);
    repeat (7) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("onesWrap", number, 8'h20);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("setIgnoresTick", number, 8'h20);

    applyStimulus(0, 0, 0, 0, 1);
    checkAll("clear", 8'h00, 2'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("startAtZero", {6'd0, state}, 8'h00);

    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("set12", number, 8'h12);
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("start12", 8'h12, 2'd1, 1'b0, 1'b0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("runIgnoresInc", number, 8'h12);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      checkOutput($sformatf("tick%0d.number", i), number, tickExp[i]);
      checkOutput($sformatf("tick%0d.done", i), {7'd0, done}, (i == 11) ? 8'h01 : 8'h00);
    end
    checkAll("reachZero", 8'h00, 2'd3, 1'b1, 1'b1);
    applyStimulus(0, 0, 0, 0, 0);
    checkAll("doneOnePulse", 8'h00, 2'd3, 1'b0, 1'b1);
    applyStimulus(0, 0, 0, 1, 0);
    checkAll("extraTick", 8'h00, 2'd3, 1'b0, 1'b1);
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("rearm12", 8'h12, 2'd0, 1'b0, 1'b0);

    applyStimulus(0, 0, 0, 0, 1);
    repeat (5) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    repeat (2) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("run03", number, 8'h03);
    applyStimulus(0, 0, 1, 1, 0);
    checkAll("pause", 8'h03, 2'd2, 1'b0, 1'b0);
    repeat (3) applyStimulus(0, 0, 0, 1, 0);
    checkAll("pauseHold", 8'h03, 2'd2, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("resume", 8'h03, 2'd1, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("resumeTick", number, 8'h02);
    repeat (2) applyStimulus(0, 0, 0, 1, 0);
    checkAll("done05", 8'h00, 2'd3, 1'b1, 1'b1);
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("rearm05", 8'h05, 2'd0, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 1);
    checkAll("clear05", 8'h00, 2'd0, 1'b0, 1'b0);

    repeat (7) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("run07", 8'h07, 2'd1, 1'b0, 1'b0);
    applyStimulus(0, 0, 1, 1, 1);
    checkAll("clearWins", 8'h00, 2'd0, 1'b0, 1'b0);

    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    repeat (4) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkAll("run34", 8'h34, 2'd1, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    checkAll("asyncReset", 8'h00, 2'd0, 1'b0, 1'b0);
    checkOutput("asyncReset5", number5, 8'h00);
    @(posedge clk);
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput($sformatf("tensMax5_%0d", i), number5, tensExp[i]);
    end
    checkOutput("tensMax5.state", {6'd0, state5}, 8'h00);
    checkOutput("tensMax5.flags", {6'd0, done5, alarm5}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
